// File: rtl/uncached_axi_bridge.sv
// uncached_axi_bridge
//   Converts one uncached SRAM-like request from the MEM stage
//   (data_req/data_addr_ok/data_data_ok) into a single-beat AXI3 read or write.
//   Only one transaction is in flight; MEM stalls until data_data_ok.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   data_*            SRAM-like slave port from MEM
//   ar*/r*            AXI read address / read data channels (master side)
//   aw*/w*/b*         AXI write address / data / response channels (master side)
//   state_dbg         current FSM state for the debug bus
module uncached_axi_bridge #(
    parameter logic [3:0] AXI_ID    = 4'd1,
    parameter bit         PHYS_MASK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    logic [1:0]  size_q,    size_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q,  rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        bready_q,  bready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;

    logic [31:0] phys_addr;
    logic [3:0]  strb_base;
    logic [3:0]  strb_shifted;
    logic [2:0]  axsize;

    // Response fields are not used: errors are not reported to MEM.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    assign phys_addr = PHYS_MASK ? {3'b000, data_addr[28:0]} : data_addr;

    always_comb begin
        case (data_size)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end

    // Upper lanes shifted past bit 3 are dropped; MEM guarantees alignment.
    assign strb_shifted = strb_base << data_addr[1:0];

    assign axsize = {1'b0, (size_q == 2'd3) ? 2'b10 : size_q};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    addr_d  = phys_addr;
                    size_d  = data_size;
                    wdata_d = data_wdata;
                    wstrb_d = strb_shifted;
                    if (data_wr) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = rdata;
                    state_d  = DONE;
                end
            end
            WR: begin
                // AW and W complete independently; leave once both flags are set,
                // including the case where both handshakes land together.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign data_addr_ok = data_req && (state_q == IDLE);
    assign data_data_ok = (state_q == DONE);
    assign data_rdata   = rdata_q;
    assign state_dbg    = state_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = axsize;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = axsize;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;

    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = wvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Directed bench for uncached_axi_bridge: a table of single transactions
// against zero-wait slaves, plus hand-written sequences for delayed AW,
// back-to-back requests and reset in the middle of a read.
module tb_uncached_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid, awlen, awcache;
    logic [31:0] awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, awready;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [2:0]  state_dbg;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    uncached_axi_bridge #(.AXI_ID(4'd1), .PHYS_MASK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .state_dbg(state_dbg)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction against a zero-wait slave, starting from IDLE at edge+1.
    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        data_req = 1'b1; data_wr = v.wr; data_size = v.size;
        data_addr = v.addr; data_wdata = v.wdata;
        #1;
        chk({p, " addr_ok"}, 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0;
        if (!v.wr) begin
            chk({p, " state RD_ADDR"}, 32'(state_dbg), 32'd1);
            chk({p, " arvalid"}, 32'(arvalid), 32'd1);
            chk({p, " araddr"}, araddr, v.exp_addr);
            chk({p, " arsize"}, 32'(arsize), 32'(v.exp_size));
            chk({p, " addr_ok busy"}, 32'(data_addr_ok), 32'd0);
            arready = 1'b1;
            tick();
            arready = 1'b0;
            chk({p, " state RD_DATA"}, 32'(state_dbg), 32'd2);
            chk({p, " arvalid drop"}, 32'(arvalid), 32'd0);
            chk({p, " rready"}, 32'(rready), 32'd1);
            rvalid = 1'b1; rdata = v.rdata_in;
            tick();
            rvalid = 1'b0; rdata = 32'h0BAD_0BAD;
            last_rdata = v.rdata_in;
            chk({p, " rready drop"}, 32'(rready), 32'd0);
        end else begin
            chk({p, " state WR"}, 32'(state_dbg), 32'd3);
            chk({p, " awvalid"}, 32'(awvalid), 32'd1);
            chk({p, " wvalid"}, 32'(wvalid), 32'd1);
            chk({p, " wlast"}, 32'(wlast), 32'd1);
            chk({p, " awaddr"}, awaddr, v.exp_addr);
            chk({p, " awsize"}, 32'(awsize), 32'(v.exp_size));
            chk({p, " wstrb"}, 32'(wstrb), 32'(v.exp_strb));
            chk({p, " wdata"}, wdata, v.wdata);
            awready = 1'b1; wready = 1'b1;
            tick();
            awready = 1'b0; wready = 1'b0;
            chk({p, " state WR_RESP"}, 32'(state_dbg), 32'd4);
            chk({p, " valids drop"}, {30'd0, awvalid, wvalid}, 32'd0);
            chk({p, " bready"}, 32'(bready), 32'd1);
            bvalid = 1'b1;
            tick();
            bvalid = 1'b0;
            chk({p, " bready drop"}, 32'(bready), 32'd0);
        end
        chk({p, " state DONE"}, 32'(state_dbg), 32'd5);
        chk({p, " data_ok"}, 32'(data_data_ok), 32'd1);
        chk({p, " data_rdata"}, data_rdata, last_rdata);
        tick();
        chk({p, " data_ok pulse"}, 32'(data_data_ok), 32'd0);
        chk({p, " back IDLE"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        int unsigned n_aok, n_dok, viol, second_aok;

        //            wr    size  addr           wdata          rdata_in       exp_addr       sz    strb
        vecs[0] = '{1'b0, 2'd2, 32'hBFD0_F000, 32'h0,         32'hDEAD_BEEF, 32'h1FD0_F000, 3'd2, 4'b1111};
        vecs[1] = '{1'b1, 2'd0, 32'hA000_0003, 32'h5500_0000, 32'h0,         32'h0000_0003, 3'd0, 4'b1000};
        vecs[2] = '{1'b1, 2'd1, 32'h0000_1002, 32'hABCD_0000, 32'h0,         32'h0000_1002, 3'd1, 4'b1100};
        vecs[3] = '{1'b0, 2'd0, 32'h8000_0001, 32'h0,         32'h1234_5678, 32'h0000_0001, 3'd0, 4'b0010};
        vecs[4] = '{1'b1, 2'd3, 32'hFFFF_FFFC, 32'h0102_0304, 32'h0,         32'h1FFF_FFFC, 3'd2, 4'b1111};
        vecs[5] = '{1'b0, 2'd1, 32'h0000_0002, 32'h0,         32'hA5A5_5A5A, 32'h0000_0002, 3'd1, 4'b1100};
        vecs[6] = '{1'b1, 2'd0, 32'h2000_0401, 32'h0000_7700, 32'h0,         32'h0000_0401, 3'd0, 4'b0010};
        vecs[7] = '{1'b0, 2'd3, 32'hC000_0010, 32'h0,         32'h0F0F_F0F0, 32'h0000_0010, 3'd2, 4'b1111};

        rst = 1'b1;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        arready = 1'b0; rid = 4'd1; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = '0; bvalid = 1'b0;
        repeat (2) tick();

        chk("reset state", 32'(state_dbg), 32'd0);
        chk("reset valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("reset oks", {30'd0, data_addr_ok, data_data_ok}, 32'd0);
        chk("reset rdata", data_rdata, 32'd0);
        chk("reset wstrb", 32'(wstrb), 32'd0);
        rst = 1'b0;

        // No request: nothing issued.
        repeat (3) tick();
        chk("idle no issue", {30'd0, arvalid, awvalid}, 32'd0);
        chk("idle state", 32'(state_dbg), 32'd0);
        chk("const arid", 32'(arid), 32'd1);
        chk("const burst/len", {arburst, awburst, arlen, awlen}, {2'b01, 2'b01, 4'd0, 4'd0});
        chk("const awid/wid", {awid, wid}, {4'd1, 4'd1});

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Store with AW delayed 4 cycles, W immediate.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h0000_0100; data_wdata = 32'hFEED_F00D;
        tick();
        data_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("dly awvalid c%0d", k), 32'(awvalid), 32'd1);
            chk($sformatf("dly wvalid c%0d", k), 32'(wvalid), (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("dly state c%0d", k), 32'(state_dbg), 32'd3);
            wready  = (k == 1);
            awready = (k == 5);
            tick();
        end
        wready = 1'b0; awready = 1'b0;
        chk("dly WR_RESP", 32'(state_dbg), 32'd4);
        chk("dly awvalid drop", 32'(awvalid), 32'd0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("dly data_ok", 32'(data_data_ok), 32'd1);
        chk("dly rdata kept", data_rdata, last_rdata);
        tick();

        // Back-to-back loads with data_req held high and an always-ready slave.
        n_aok = 0; n_dok = 0; viol = 0; second_aok = 0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0040;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_0001;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (data_addr_ok && state_dbg != 3'd0) viol++;
            if (data_addr_ok) begin
                n_aok++;
                if (n_aok == 2) second_aok = c;
            end
            if (data_data_ok) n_dok++;
            tick();
        end
        data_req = 1'b0; arready = 1'b0; rvalid = 1'b0;
        chk("b2b addr_ok count", n_aok, 32'd2);
        chk("b2b second accept cycle", second_aok, 32'd4);
        chk("b2b data_ok count", n_dok, 32'd2);
        chk("b2b busy accept", viol, 32'd0);
        chk("b2b rdata", data_rdata, 32'hCAFE_0001);
        tick();

        // Reset while waiting in RD_DATA.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0080;
        tick();
        data_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rst pre state", 32'(state_dbg), 32'd2);
        chk("rst pre rready", 32'(rready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async state", 32'(state_dbg), 32'd0);
        chk("rst async valids", {29'd0, arvalid, rready, data_data_ok}, 32'd0);
        chk("rst async rdata", data_rdata, 32'd0);
        tick();
        rst = 1'b0;
        last_rdata = '0;
        chk("rst held idle", 32'(state_dbg), 32'd0);
        run_vec(8, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
